// File: rtl/key_debounce_if.sv
// Key conditioning bundle: raw active-low pins in, debounced level and edge strobes out.
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_out;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                any_press;

  modport master (
    output key_n,
    input  key_out, key_press, key_release, any_press
  );

  modport slave (
    input  key_n,
    output key_out, key_press, key_release, any_press
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: per-key 2-flop sync, stability counter, registered
// level plus one-cycle press/release strobes.
module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rls,
  output logic press_nxt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  logic             diff, done;

  assign diff      = s2 ^ level;
  assign done      = diff && (cnt == LAST);
  assign press_nxt = done & s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
      rls   <= 1'b0;
    end else begin
      s1    <= ~key_n;
      s2    <= s1;
      press <= done & s2;
      rls   <= done & ~s2;
      // any return to the accepted level restarts the stability window
      if (!diff) begin
        cnt <= '0;
      end else if (done) begin
        cnt   <= '0;
        level <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  key_debounce_if.slave  bus
);
  logic [NUM_KEYS-1:0] level, press, rls, press_nxt;
  logic                any;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_lane (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .key_n     (bus.key_n[i]),
      .level     (level[i]),
      .press     (press[i]),
      .rls       (rls[i]),
      .press_nxt (press_nxt[i])
    );
  end

  // registered from the lanes' next-press terms so it lines up with key_press
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) any <= 1'b0;
    else                any <= |press_nxt;
  end

  assign bus.key_out     = level;
  assign bus.key_press   = press;
  assign bus.key_release = rls;
  assign bus.any_press   = any;
endmodule
